pn_burst_ctrl: RTL and testbench

PN_BURST_CTRL -- requirements
Module: pn_burst_ctrl

---
 rtl/pn_burst_ctrl_pkg.sv | 29 ++
 rtl/pn_burst_ctrl_if.sv | 36 +++
 rtl/pn_burst_ctrl_lfsr.sv | 30 +++
 rtl/pn_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_pn_burst_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pn_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pn_ctrl_pkg : shared types, LFSR geometry and next-state helper
// Rev 1.0
// ============================================================================
package pn_ctrl_pkg;

  localparam int                LFSR_W    = 3;
  localparam logic [LFSR_W-1:0] DEF_SEED  = 3'b001;
  localparam int                TAP_HI    = 2;
  localparam int                TAP_LO    = 1;

  localparam int                CHIP_W    = 3;
  localparam logic [CHIP_W-1:0] CHIP_LAST = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Shift left, feed the tap XOR into the LSB: maximal-length, period 7.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pn_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// pn_burst_ctrl_if : control, configuration and chip-stream signals
// Rev 1.0
// ============================================================================
interface pn_burst_ctrl_if
  import pn_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic              start;
  logic              stop;
  logic [LFSR_W-1:0] cfg_seed;
  logic [CNT_W-1:0]  num_periods;
  logic              chip_out;
  logic              chip_valid;
  logic              chip_ready;
  logic              chip_last;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              cfg_err;

  modport master (
    output start, stop, cfg_seed, num_periods, chip_ready,
    input  chip_out, chip_valid, chip_last, busy, done, aborted, cfg_err
  );

  modport slave (
    input  start, stop, cfg_seed, num_periods, chip_ready,
    output chip_out, chip_valid, chip_last, busy, done, aborted, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/pn_burst_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
// pn_lfsr : 3-bit maximal-length Fibonacci LFSR with load and advance
// Rev 1.0
// ============================================================================
module pn_lfsr
#(
  parameter logic [pn_ctrl_pkg::LFSR_W-1:0] DEF_SEED = pn_ctrl_pkg::DEF_SEED
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [pn_ctrl_pkg::LFSR_W-1:0]   seed,
  input  logic                             adv,
  output logic [pn_ctrl_pkg::LFSR_W-1:0]   q
);
  import pn_ctrl_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= DEF_SEED;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pn_burst_ctrl.sv
`default_nettype none
// ============================================================================
// pn_burst_ctrl : bursts of 7-chip PN periods over a valid/ready stream
// Rev 1.0
// ============================================================================
module pn_burst_ctrl
#(
  parameter int                             CNT_W    = 8,
  parameter logic [pn_ctrl_pkg::LFSR_W-1:0] DEF_SEED = pn_ctrl_pkg::DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  pn_burst_ctrl_if.slave   bus
);
  import pn_ctrl_pkg::*;

  state_t             state;
  state_t             next_state;

  logic [LFSR_W-1:0]  seed_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   per_cnt;
  logic [CHIP_W-1:0]  chip_cnt;
  logic               stop_pend;

  logic               done_q;
  logic               aborted_q;
  logic               cfg_err_q;

  logic               cfg_ok;
  logic               handshake;
  logic               end_hs;
  logic               abort_hs;

  logic               busy_c;
  logic               valid_c;
  logic               last_c;
  logic               lfsr_load;
  logic               lfsr_adv;

  assign cfg_ok    = (bus.cfg_seed != '0) && (bus.num_periods != '0);
  assign handshake = valid_c && bus.chip_ready;
  // A stop arriving with the handshake itself still makes that chip the final one.
  assign end_hs    = handshake && (last_c || stop_pend || bus.stop);
  assign abort_hs  = handshake && !last_c && (stop_pend || bus.stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start && cfg_ok) next_state = S_LOAD;
      S_LOAD:  next_state = S_RUN;
      S_RUN:   if (end_hs) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c    = (state != S_IDLE);
    valid_c   = (state == S_RUN);
    last_c    = valid_c && (chip_cnt == CHIP_LAST) &&
                (per_cnt == num_q - CNT_W'(1)) && !stop_pend;
    lfsr_load = (state == S_LOAD);
    lfsr_adv  = valid_c && bus.chip_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q    <= '0;
      num_q     <= '0;
      chip_cnt  <= '0;
      per_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      if ((state == S_IDLE) && bus.start && cfg_ok) begin
        seed_q <= bus.cfg_seed;
        num_q  <= bus.num_periods;
      end

      if (state == S_LOAD) begin
        chip_cnt <= '0;
        per_cnt  <= '0;
      end else if (handshake) begin
        if (chip_cnt == CHIP_LAST) begin
          chip_cnt <= '0;
          per_cnt  <= per_cnt + CNT_W'(1);
        end else begin
          chip_cnt <= chip_cnt + CHIP_W'(1);
        end
      end

      if (((state == S_LOAD) || (state == S_RUN)) && bus.stop && !end_hs) begin
        stop_pend <= 1'b1;
      end else if ((state == S_IDLE) || (state == S_DONE)) begin
        stop_pend <= 1'b0;
      end
    end
  end

  // Status pulses are registered so they line up with the DONE state / the cycle after a rejected start.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= (state == S_RUN) && end_hs;
      aborted_q <= (state == S_RUN) && abort_hs;
      cfg_err_q <= (state == S_IDLE) && bus.start && !cfg_ok;
    end
  end

  pn_lfsr #(
    .DEF_SEED (DEF_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed_q),
    .adv  (lfsr_adv),
    .q    (lfsr_q)
  );

  assign bus.chip_out   = lfsr_q[LFSR_W-1];
  assign bus.chip_valid = valid_c;
  assign bus.chip_last  = last_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pn_burst_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pn_burst_ctrl : scoreboard bench with an m-sequence reference model
// Rev 1.0
// ============================================================================
module tb_pn_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pn_burst_ctrl_if #(.CNT_W(8)) bus ();

  pn_burst_ctrl #(
    .CNT_W    (8),
    .DEF_SEED (3'b001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic chip;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  bit   done_q[$];
  int   err_pend = 0;
  int   checks   = 0;
  int   errors   = 0;

  // Successive register states of the 7-state m-sequence starting at 001; chip = state bit 2.
  int seq_state [7] = '{1, 2, 5, 3, 7, 6, 4};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.chip_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chip: got chip %0d expected none at %0t", bus.chip_out, $time);
        end else begin
          check("chip_out", bus.chip_out, exp_q[0].chip);
          check("chip_last", bus.chip_last, exp_q[0].last);
          if (bus.chip_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
        end else begin
          bit ab;
          ab = done_q.pop_front();
          check("aborted", bus.aborted, ab);
          check("chips_left_at_done", exp_q.size(), 0);
        end
      end
      if (bus.cfg_err) begin
        if (err_pend == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cfg_err: got cfg_err=1 expected 0 at %0t", $time);
        end else begin
          err_pend--;
          check("busy_on_cfg_err", bus.busy, 0);
        end
      end
    end
  end

  // mode: 0 random ready, 1 ready held high, 2 ready toggling 1/0
  task automatic run_burst(input int seed, input int num, input int stop_k, input int hold,
                           input int mode, input bit spur, input int rst_k);
    int total, n, off, acc, cyc, hold_left;
    bit ab, stop_sent, hs, tog, fin, was_rst;
    total = 7 * num;
    ab    = (stop_k >= 0);
    n     = ab ? stop_k + 1 : total;
    off   = 0;
    for (int i = 0; i < 7; i++) if (seq_state[i] == seed) off = i;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   st;
      st     = seq_state[(off + i) % 7];
      e.chip = st[2];
      e.last = !ab && (i == n - 1);
      exp_q.push_back(e);
    end
    done_q.push_back(ab);

    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.cfg_seed    = 3'(seed);
    bus.num_periods = 8'(num);
    bus.chip_ready  = 1'b0;
    bus.stop        = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_in_load", bus.busy, 1);
    check("valid_in_load", bus.chip_valid, 0);
    @(posedge clk); #1;
    check("first_valid_latency", bus.chip_valid, 1);

    acc = 0; cyc = 0; hold_left = 0; stop_sent = 0; tog = 1; fin = 0; was_rst = 0;
    while (!fin && cyc < 20000) begin
      cyc++;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (spur && acc == 3 && bus.busy) begin
        bus.start       = 1'b1;
        bus.cfg_seed    = 3'd7;
        bus.num_periods = 8'd1;
      end
      if (ab && !stop_sent && acc == stop_k && bus.chip_valid) begin
        bus.stop  = 1'b1;
        stop_sent = 1'b1;
        hold_left = hold;
      end
      case (mode)
        0:       bus.chip_ready = 1'($urandom_range(0, 1));
        1:       bus.chip_ready = 1'b1;
        default: bus.chip_ready = tog;
      endcase
      tog = !tog;
      if (hold_left > 0) begin
        bus.chip_ready = 1'b0;
        hold_left--;
      end
      if (rst_k >= 0 && acc == rst_k && bus.chip_valid) begin
        rst            = 1'b1;
        bus.chip_ready = 1'b0;
      end
      @(negedge clk);
      hs = bus.chip_valid && bus.chip_ready;
      @(posedge clk); #1;
      if (hs) acc++;
      if (rst) begin
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        check("busy_after_rst", bus.busy, 0);
        check("valid_after_rst", bus.chip_valid, 0);
        check("done_after_rst", bus.done, 0);
        was_rst = 1'b1;
        fin     = 1'b1;
      end else if (!bus.busy) begin
        fin = 1'b1;
      end
    end
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.chip_ready = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got busy=%0d after %0d cycles expected 0", bus.busy, cyc);
    end
    if (!was_rst) begin
      check("accepted_chips", acc, n);
      if (mode == 1 && hold == 0) check("burst_cycles", cyc, n + 1);
    end
    @(posedge clk); #1;
    check("idle_after_burst", bus.busy, 0);
  endtask

  task automatic bad_start(input int seed, input int num);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.cfg_seed    = 3'(seed);
    bus.num_periods = 8'(num);
    err_pend++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_bad_start", bus.busy, 0);
    check("cfg_err_rise", bus.cfg_err, 1);
    @(posedge clk); #1;
    check("cfg_err_width", bus.cfg_err, 0);
    check("busy_bad_start_2", bus.busy, 0);
    check("cfg_err_consumed", err_pend, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int seed, num, stop_k, hold, mode;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.cfg_seed    = '0;
    bus.num_periods = '0;
    bus.chip_ready  = 1'b0;
    rst             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_chip_valid", bus.chip_valid, 0);
    check("rst_chip_last", bus.chip_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_chip_out", bus.chip_out, 0);
    rst = 1'b0;

    run_burst(1, 1, -1, 0, 1, 0, -1);
    run_burst(1, 2, -1, 0, 2, 0, -1);
    bad_start(0, 3);
    bad_start(5, 0);
    run_burst(3, 3, 4, 3, 1, 0, -1);
    run_burst(1, 3, -1, 0, 1, 0, 10);
    run_burst(6, 2, -1, 0, 1, 0, -1);
    run_burst(2, 2, -1, 0, 0, 1, -1);
    run_burst(4, 255, -1, 0, 1, 0, -1);

    for (int k = 0; k < 12; k++) begin
      seed   = $urandom_range(1, 7);
      num    = $urandom_range(1, 4);
      mode   = $urandom_range(0, 2);
      stop_k = -1;
      hold   = 0;
      if ($urandom_range(0, 2) == 0) begin
        stop_k = $urandom_range(0, 7 * num - 2);
        hold   = $urandom_range(0, 2);
      end
      run_burst(seed, num, stop_k, hold, mode, 0, -1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("cfg_err_drained", err_pend, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
